// File: rtl/hazard_ctrl_pkg.sv
// Shared processor definitions used by the pipeline hazard controller:
// FSM state encoding, wait/stall limits and the register-match helper.
package hazard_ctrl_pkg;

  // Controller FSM states. These are plain constants so older code that
  // compares raw 2-bit values keeps working.
  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
  localparam logic [1:0] ST_FLUSH_PEND = 2'd2;

  // The wait counter saturates here, and reaching it flags a memory timeout.
  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  // stall_cycles saturates here instead of wrapping.
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // An ID instruction depends on a producer when the producer's destination
  // equals src1, or equals src2 and the instruction actually reads src2.
  function automatic logic src_match(input logic [3:0] dest,
                                     input logic [3:0] s1,
                                     input logic [3:0] s2,
                                     input logic       two);
    return (dest == s1) | (two & (dest == s2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Purely combinational read-after-write hazard compare between the ID
// instruction's sources and the EXE / MEM destinations.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       forward_en,
  input  logic       two_src,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic [3:0] exe_dest,
  input  logic [3:0] mem_dest,
  input  logic       exe_wb_en,
  input  logic       mem_wb_en,
  input  logic       exe_mem_r_en,
  output logic       raw_hazard
);

  logic exe_match;
  logic mem_match;
  logic load_use;
  logic no_fwd_hazard;

  assign exe_match = src_match(exe_dest, src1, src2, two_src);
  assign mem_match = src_match(mem_dest, src1, src2, two_src);

  // With forwarding, only a load in EXE cannot be bypassed in time.
  assign load_use = exe_wb_en & exe_mem_r_en & exe_match;

  // Without forwarding, any pending write in EXE or MEM must drain first.
  assign no_fwd_hazard = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);

  assign raw_hazard = forward_en ? load_use : no_fwd_hazard;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-hazard stalls, branch flushes, and
// whole-pipe freezes while data memory is busy. A branch resolved during a
// freeze is remembered and its flush is issued on the first free cycle.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        forward_en,
  input  logic        two_src,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic [3:0]  exe_dest,
  input  logic [3:0]  mem_dest,
  input  logic        exe_wb_en,
  input  logic        mem_wb_en,
  input  logic        exe_mem_r_en,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        hazard_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        pipe_freeze,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       flush_owed;
  logic       flush_owed_next;
  logic [7:0] wait_cnt;
  logic       raw_hazard;
  logic       wait_start;
  logic       in_wait;
  logic       enter_wait;
  logic       stall_raw;
  logic       if_flush_raw;
  logic       id_flush_raw;
  logic       freeze_raw;

  hazard_detect u_detect (
    .forward_en   (forward_en),
    .two_src      (two_src),
    .src1         (src1),
    .src2         (src2),
    .exe_dest     (exe_dest),
    .mem_dest     (mem_dest),
    .exe_wb_en    (exe_wb_en),
    .mem_wb_en    (mem_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .raw_hazard   (raw_hazard)
  );

  assign wait_start = mem_req & ~mem_ready;
  assign in_wait    = (state == ST_MEM_WAIT) | (state == ST_FLUSH_PEND);
  assign enter_wait = (state == ST_RUN) & (state_next != ST_RUN);

  // Next-state and output decode; priority is freeze, then flush, then stall.
  always_comb begin
    state_next      = state;
    flush_owed_next = 1'b0;
    stall_raw       = 1'b0;
    if_flush_raw    = 1'b0;
    id_flush_raw    = 1'b0;
    freeze_raw      = 1'b0;
    case (state)
      ST_RUN: begin
        if (wait_start) begin
          // An owed flush that collides with a new freeze must survive it.
          freeze_raw = 1'b1;
          state_next = (branch_taken | flush_owed) ? ST_FLUSH_PEND : ST_MEM_WAIT;
        end else if (branch_taken | flush_owed) begin
          if_flush_raw = 1'b1;
          id_flush_raw = 1'b1;
        end else if (raw_hazard) begin
          stall_raw    = 1'b1;
          id_flush_raw = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        freeze_raw = 1'b1;
        if (mem_ready) begin
          state_next      = ST_RUN;
          flush_owed_next = branch_taken;
        end else if (branch_taken) begin
          state_next = ST_FLUSH_PEND;
        end
      end
      ST_FLUSH_PEND: begin
        freeze_raw = 1'b1;
        if (mem_ready) begin
          state_next      = ST_RUN;
          flush_owed_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Control outputs go quiet the instant reset is asserted.
  assign hazard_stall = stall_raw & ~rst;
  assign if_flush     = if_flush_raw & ~rst;
  assign id_flush     = id_flush_raw & ~rst;
  assign pipe_freeze  = freeze_raw & ~rst;

  // FSM state and the deferred-flush marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      flush_owed <= 1'b0;
    end else begin
      state      <= state_next;
      flush_owed <= flush_owed_next;
    end
  end

  // Wait counter: restarts on each new wait, then counts up to the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (enter_wait) begin
      wait_cnt <= 8'd0;
    end else if (in_wait && (wait_cnt != WAIT_LIMIT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Sticky timeout flag; the FSM keeps waiting regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (in_wait && (wait_cnt == WAIT_LIMIT)) begin
      mem_timeout <= 1'b1;
    end
  end

  // Saturating count of cycles in which the pipeline did not advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if ((freeze_raw || stall_raw) && (stall_cycles != STALL_MAX)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed
// expectations, a monitor pops and compares on each falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en;
  logic        two_src;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [3:0]  exe_dest;
  logic [3:0]  mem_dest;
  logic        exe_wb_en;
  logic        mem_wb_en;
  logic        exe_mem_r_en;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        hazard_stall;
  logic        if_flush;
  logic        id_flush;
  logic        pipe_freeze;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  typedef struct {
    logic       rst;
    logic       forward_en;
    logic       two_src;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] exe_dest;
    logic [3:0] mem_dest;
    logic       exe_wb_en;
    logic       mem_wb_en;
    logic       exe_mem_r_en;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;
  } in_t;

  typedef struct {
    string       name;
    logic [4:0]  flags;
    logic        chk_mt;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_sc = 16'd0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .forward_en   (forward_en),
    .two_src      (two_src),
    .src1         (src1),
    .src2         (src2),
    .exe_dest     (exe_dest),
    .mem_dest     (mem_dest),
    .exe_wb_en    (exe_wb_en),
    .mem_wb_en    (mem_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .hazard_stall (hazard_stall),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .pipe_freeze  (pipe_freeze),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t v;
    v.rst          = 1'b0;
    v.forward_en   = 1'b0;
    v.two_src      = 1'b0;
    v.src1         = 4'd1;
    v.src2         = 4'd2;
    v.exe_dest     = 4'd0;
    v.mem_dest     = 4'd0;
    v.exe_wb_en    = 1'b0;
    v.mem_wb_en    = 1'b0;
    v.exe_mem_r_en = 1'b0;
    v.branch_taken = 1'b0;
    v.mem_req      = 1'b0;
    v.mem_ready    = 1'b0;
    return v;
  endfunction

  function automatic in_t load_use();
    in_t v;
    v              = idle();
    v.forward_en   = 1'b1;
    v.exe_mem_r_en = 1'b1;
    v.exe_wb_en    = 1'b1;
    v.exe_dest     = 4'd3;
    v.src1         = 4'd3;
    return v;
  endfunction

  task automatic drive(input in_t v);
    rst          = v.rst;
    forward_en   = v.forward_en;
    two_src      = v.two_src;
    src1         = v.src1;
    src2         = v.src2;
    exe_dest     = v.exe_dest;
    mem_dest     = v.mem_dest;
    exe_wb_en    = v.exe_wb_en;
    mem_wb_en    = v.mem_wb_en;
    exe_mem_r_en = v.exe_mem_r_en;
    branch_taken = v.branch_taken;
    mem_req      = v.mem_req;
    mem_ready    = v.mem_ready;
  endtask

  // flags = {hazard_stall, if_flush, id_flush, pipe_freeze, mem_timeout}
  task automatic applyStimulus(input string name, input in_t v,
                               input logic [4:0] flags, input logic chk_mt);
    exp_t x;
    @(posedge clk);
    #1;
    drive(v);
    if (v.rst) exp_sc = 16'd0;
    x.name   = name;
    x.flags  = flags;
    x.chk_mt = chk_mt;
    x.sc     = exp_sc;
    sb_q.push_back(x);
    if (!v.rst && (flags[4] || flags[1]) && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
  endtask

  task automatic checkOutput(input exp_t x);
    logic [4:0] act;
    logic [4:0] req;
    act = {hazard_stall, if_flush, id_flush, pipe_freeze, mem_timeout};
    req = x.flags;
    if (!x.chk_mt) begin
      act[0] = 1'b0;
      req[0] = 1'b0;
    end
    checks++;
    if (act !== req || stall_cycles !== x.sc) begin
      failures++;
      $display("[TB] FAIL %s: got hs/iff/idf/pf/mt=%b stall_cycles=%0d, expected %b stall_cycles=%0d",
               x.name, act, stall_cycles, req, x.sc);
    end
  endtask

  // Monitor: outputs are combinational, so every vector is due mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  initial begin
    in_t v;
    logic mt_exp;
    v = idle();
    v.rst = 1'b1;
    drive(v);

    applyStimulus("reset", v, 5'b00000, 1'b1);
    applyStimulus("idle", idle(), 5'b00000, 1'b1);

    // Data hazards
    applyStimulus("load_use", load_use(), 5'b10100, 1'b1);
    applyStimulus("after_load_use", idle(), 5'b00000, 1'b1);
    v = load_use(); v.src1 = 4'd1; v.exe_dest = 4'd4; v.src2 = 4'd4; v.two_src = 1'b0;
    applyStimulus("fwd_src2_unused", v, 5'b00000, 1'b1);
    v.two_src = 1'b1;
    applyStimulus("fwd_src2_used", v, 5'b10100, 1'b1);
    v = load_use(); v.exe_mem_r_en = 1'b0;
    applyStimulus("fwd_not_load", v, 5'b00000, 1'b1);
    v = idle(); v.mem_wb_en = 1'b1; v.mem_dest = 4'd5; v.two_src = 1'b1; v.src2 = 4'd5;
    applyStimulus("nofwd_mem_src2", v, 5'b10100, 1'b1);
    v.two_src = 1'b0;
    applyStimulus("nofwd_mem_src2_unused", v, 5'b00000, 1'b1);
    v = idle(); v.exe_wb_en = 1'b1; v.exe_dest = 4'd7; v.src1 = 4'd7;
    applyStimulus("nofwd_exe_src1", v, 5'b10100, 1'b1);
    v.exe_wb_en = 1'b0;
    applyStimulus("nofwd_no_writeback", v, 5'b00000, 1'b1);

    // Branch flushes in RUN
    v = load_use(); v.branch_taken = 1'b1;
    applyStimulus("branch_plus_load_use", v, 5'b01100, 1'b1);
    v = idle(); v.branch_taken = 1'b1;
    applyStimulus("branch_only", v, 5'b01100, 1'b1);
    v = idle(); v.mem_req = 1'b1; v.mem_ready = 1'b1;
    applyStimulus("mem_hit", v, 5'b00000, 1'b1);

    // Branch during a memory wait
    v = idle(); v.mem_req = 1'b1;
    applyStimulus("bw_cycle1", v, 5'b00010, 1'b1);
    v.branch_taken = 1'b1;
    applyStimulus("bw_cycle2", v, 5'b00010, 1'b1);
    v.branch_taken = 1'b0;
    applyStimulus("bw_cycle3", v, 5'b00010, 1'b1);
    v.mem_ready = 1'b1;
    applyStimulus("bw_cycle4", v, 5'b00010, 1'b1);
    applyStimulus("bw_cycle5_flush", idle(), 5'b01100, 1'b1);
    applyStimulus("bw_cycle6", idle(), 5'b00000, 1'b1);

    // Freeze beats branch and hazard; deferred flush beats hazard
    v = load_use(); v.branch_taken = 1'b1; v.mem_req = 1'b1;
    applyStimulus("freeze_over_all", v, 5'b00010, 1'b1);
    v = idle(); v.mem_req = 1'b1; v.mem_ready = 1'b1;
    applyStimulus("pend_ready", v, 5'b00010, 1'b1);
    applyStimulus("deferred_over_hazard", load_use(), 5'b01100, 1'b1);
    applyStimulus("after_deferred", idle(), 5'b00000, 1'b1);

    // Asynchronous reset in the middle of a wait with a latched branch
    v = idle(); v.mem_req = 1'b1;
    applyStimulus("rw_cycle1", v, 5'b00010, 1'b1);
    v.branch_taken = 1'b1;
    applyStimulus("rw_cycle2", v, 5'b00010, 1'b1);
    v.branch_taken = 1'b0; v.rst = 1'b1;
    applyStimulus("rw_reset", v, 5'b00000, 1'b1);
    applyStimulus("rw_no_flush", idle(), 5'b00000, 1'b1);
    applyStimulus("rw_idle", idle(), 5'b00000, 1'b1);

    // Memory timeout: mem_timeout is left unchecked around the threshold
    v = idle(); v.mem_req = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      mt_exp = (i > 260);
      applyStimulus($sformatf("timeout_c%0d", i), v, {4'b0001, mt_exp},
                    (i < 250) || (i > 260));
    end
    v.mem_ready = 1'b1;
    applyStimulus("timeout_ready", v, 5'b00011, 1'b1);
    applyStimulus("timeout_sticky", idle(), 5'b00001, 1'b1);
    v = idle(); v.rst = 1'b1;
    applyStimulus("timeout_reset", v, 5'b00000, 1'b1);
    applyStimulus("post_reset_idle", idle(), 5'b00000, 1'b1);

    for (int n = 0; n < 5 && sb_q.size() > 0; n++) @(posedge clk);
    if (sb_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock and reset ports SHALL be named clk and rst.
REQ-002 Ports, name  direction  width  meaning:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- forward_en  in  1  forwarding unit enabled
- two_src  in  1  ID instruction reads src2
- src1, src2  in  4 each  ID source register numbers
- exe_dest, mem_dest  in  4 each  destination register in EXE / MEM
- exe_wb_en, mem_wb_en  in  1 each  EXE / MEM instruction writes back
- exe_mem_r_en  in  1  EXE instruction is a load
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM stage has a read or write
- mem_ready  in  1  data memory completes this cycle
- hazard_stall  out  1  hold PC and IF register
- if_flush  out  1  clear IF register
- id_flush  out  1  drives Flush of the ID/EX pipeline register
- pipe_freeze  out  1  hold every pipeline register and PC
- mem_timeout  out  1  sticky memory-timeout error
- stall_cycles  out  16  saturating count of non-advancing cycles

Function
REQ-003 Raw hazard (comb.) SHALL be defined as follows:
- forward_en=1: exe_wb_en & exe_mem_r_en & (exe_dest==src1 | two_src & exe_dest==src2).
- forward_en=0: (exe_wb_en & match exe_dest) | (mem_wb_en & match mem_dest), using the same src1/src2/two_src rule.
REQ-004 FSM states SHALL be RUN, MEM_WAIT, FLUSH_PEND.
REQ-005 RUN -> MEM_WAIT SHALL occur when mem_req=1 and mem_ready=0, with branch_taken=0.
REQ-006 RUN -> FLUSH_PEND SHALL occur when mem_req=1, mem_ready=0 and branch_taken=1.
REQ-007 MEM_WAIT -> FLUSH_PEND SHALL occur when branch_taken=1 while waiting; the branch is latched.
REQ-008 MEM_WAIT/FLUSH_PEND -> RUN SHALL occur on the cycle after mem_ready=1.
REQ-009 In MEM_WAIT and FLUSH_PEND, pipe_freeze SHALL be 1, and hazard_stall, if_flush and id_flush SHALL be 0.
REQ-010 On the first RUN cycle after FLUSH_PEND, if_flush=1 and id_flush=1 SHALL be asserted for exactly one cycle (the deferred branch flush).
REQ-011 In RUN with branch_taken=1 and no new wait, if_flush=1, id_flush=1 and hazard_stall=0 SHALL hold; flush SHALL win over a raw hazard.
REQ-012 In RUN with a raw hazard and no branch, hazard_stall=1 and id_flush=1 SHALL hold (bubble insertion), with if_flush=0.
REQ-013 In RUN with mem_req=1 and mem_ready=0, pipe_freeze SHALL be 1 in that same cycle (combinational), and flushes and stalls SHALL be suppressed.
REQ-014 Priority SHALL be pipe_freeze > branch flush > hazard stall.
REQ-015 An 8-bit wait counter SHALL clear on entering MEM_WAIT/FLUSH_PEND and increment each waiting cycle.
REQ-016 When the wait counter reaches 255, mem_timeout SHALL set and remain set until rst; the FSM SHALL keep waiting.
REQ-017 stall_cycles SHALL increment by 1 on every cycle with pipe_freeze=1 or hazard_stall=1, and SHALL saturate at 16'hFFFF.
REQ-018 All outputs except stall_cycles and mem_timeout SHALL be combinational from state and inputs; no input-to-output latency.

Reset
REQ-019 rst SHALL force, asynchronously: state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0.
REQ-020 Any latched branch SHALL be discarded on rst.
REQ-021 Reset asserted mid-MEM_WAIT SHALL drop pipe_freeze immediately.
REQ-022 No deferred flush SHALL issue after reset.

Structure
REQ-023 The FSM state encoding and the constant WAIT_LIMIT=255 SHALL reside in the shared processor package.
REQ-024 The raw-hazard compare SHALL be one sub-module, hazard_detect (purely combinational); the FSM and counters SHALL remain in hazard_ctrl.

Verification
REQ-025 Load-use: forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, src1=3 -> hazard_stall=1, id_flush=1, if_flush=0; stall_cycles increments by 1.
REQ-026 No forwarding: forward_en=0, mem_wb_en=1, mem_dest=5, two_src=1, src2=5 -> stall; the same case with two_src=0 -> no stall.
REQ-027 Branch during wait: mem_req=1 and mem_ready=0 for 4 cycles, branch_taken=1 in cycle 2, mem_ready=1 in cycle 4 -> pipe_freeze=1 for cycles 1-4; single-cycle if_flush=id_flush=1 in cycle 5.
REQ-028 Branch plus hazard in RUN: branch_taken=1 together with load-use -> if_flush=id_flush=1, hazard_stall=0.
REQ-029 Timeout: mem_ready held 0 for 300 cycles -> mem_timeout=1 after cycle 255 and stays 1 after mem_ready=1; cleared only by rst.
REQ-030 Async reset mid-wait: rst pulsed in MEM_WAIT between clock edges -> all outputs 0 immediately; no flush on the next RUN cycle; stall_cycles=0.
